// File: rtl/riscv_dcache_mem_bridge.sv
// riscv_dcache_mem_bridge: splits 128-bit cache line refills/writebacks into ascending 32-bit bus beats.
// Bus outputs and o_mem_ready decode from registered state only.
module riscv_dcache_mem_bridge #(
    parameter int DATA_WIDTH = 128,
    parameter int BUS_WIDTH  = 32,
    parameter int BEATS      = DATA_WIDTH / BUS_WIDTH,
    parameter int S_ADDR     = 23,
    parameter int ADDR       = S_ADDR + $clog2(DATA_WIDTH / 8)
) (
    input  logic                  i_riscv_dcache_clk,
    input  logic                  i_riscv_dcache_rst,
    input  logic                  i_mem_wren,
    input  logic                  i_mem_rden,
    input  logic [S_ADDR-1:0]     i_mem_addr,
    input  logic [DATA_WIDTH-1:0] i_mem_wdata,
    output logic                  o_mem_ready,
    output logic [DATA_WIDTH-1:0] o_mem_data_out,
    output logic                  o_bus_req,
    output logic                  o_bus_we,
    output logic [ADDR-1:0]       o_bus_addr,
    output logic [BUS_WIDTH-1:0]  o_bus_wdata,
    input  logic                  i_bus_ack,
    input  logic [BUS_WIDTH-1:0]  i_bus_rdata
);
    localparam int BW  = $clog2(BEATS);
    localparam int OFF = ADDR - S_ADDR - BW;

    typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

    state_t                r_state;
    logic [BW-1:0]         r_beat;
    logic [S_ADDR-1:0]     r_addr;
    logic [DATA_WIDTH-1:0] r_line;
    logic [DATA_WIDTH-1:0] w_line_fill;
    logic                  w_busy;
    logic                  w_last;

    assign w_busy = (r_state == WRITE) || (r_state == READ);
    assign w_last = r_beat == BW'(BEATS - 1);

    // Line with the current read beat merged in, so the final beat reaches o_mem_data_out directly
    always_comb begin
        w_line_fill = r_line;
        w_line_fill[r_beat*BUS_WIDTH +: BUS_WIDTH] = i_bus_rdata;
    end

    assign o_mem_ready = r_state == DONE;
    assign o_bus_req   = w_busy;
    assign o_bus_we    = r_state == WRITE;
    assign o_bus_addr  = w_busy ? {r_addr, r_beat, {OFF{1'b0}}} : '0;
    assign o_bus_wdata = o_bus_we ? r_line[r_beat*BUS_WIDTH +: BUS_WIDTH] : '0;

    always_ff @(posedge i_riscv_dcache_clk or posedge i_riscv_dcache_rst) begin
        if (i_riscv_dcache_rst) begin
            r_state        <= IDLE;
            r_beat         <= '0;
            r_addr         <= '0;
            r_line         <= '0;
            o_mem_data_out <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_beat <= '0;
                    if (i_mem_wren) begin
                        r_addr  <= i_mem_addr;
                        r_line  <= i_mem_wdata;
                        r_state <= WRITE;
                    end else if (i_mem_rden) begin
                        r_addr  <= i_mem_addr;
                        r_state <= READ;
                    end
                end
                WRITE: begin
                    if (i_bus_ack) begin
                        r_beat  <= r_beat + 1'b1;
                        r_state <= w_last ? DONE : WRITE;
                    end
                end
                READ: begin
                    if (i_bus_ack) begin
                        r_line <= w_line_fill;
                        r_beat <= r_beat + 1'b1;
                        if (w_last) begin
                            o_mem_data_out <= w_line_fill;
                            r_state        <= DONE;
                        end
                    end
                end
                DONE: r_state <= IDLE;
            endcase
        end
    end
endmodule
